alu_issue: RTL and testbench
============================

Name: alu_issue

Overview:
- Issue stage directly upstream of the ALU.
- Holds the 2-read/1-write architectural register file and a per-register pending scoreboard.
- Accepts decoded ops (rs1, rs2, rd, op) via valid/ready, reads operands with writeback bypass, and stalls on RAW/WAW hazards.
- Presents r1/r2/op/rd to the ALU from a one-entry registered output with its own valid/ready; results return on the wb_* port.

Parameters:
- XLEN, 32, datapath width (ALU operand width)
- NREG, 32, number of architectural registers; register 0 hardwired to zero
- AW, 5, register address width (log2 NREG)
- OPW, 3, ALU op-code width

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  decoded op available
- in_ready  out  1  stage accepts op this cycle
- in_rs1  in  AW  source register 1
- in_rs2  in  AW  source register 2
- in_rd  in  AW  destination register (0 = no writeback)
- in_op  in  OPW  ALU op code, passed through
- out_valid  out  1  operands valid toward ALU
- out_ready  in  1  ALU/downstream consumes
- out_r1  out  XLEN  operand 1
- out_r2  out  XLEN  operand 2
- out_op  out  OPW  ALU op code
- out_rd  out  AW  destination tag
- wb_en  in  1  writeback strobe from result stage
- wb_addr  in  AW  writeback register
- wb_data  in  XLEN  writeback value

Behaviour:
- Reset (synchronous, rst=1 at a rising edge): all registers=0, all pending bits=0, out_valid=0, out_r1/out_r2/out_op/out_rd=0. in_ready=0 while rst=1.
- Register file:
  - Reads of register 0 return 0.
  - Writes with wb_addr=0 are ignored.
  - Write takes effect at the clock edge when wb_en=1.
- Bypass: if wb_en=1 and wb_addr==rsN!=0 in the same cycle, the operand is wb_data, not the stale array value.
- Scoreboard:
  - pending[rd] is set on accept (in_valid&in_ready) when in_rd!=0.
  - pending[wb_addr] is cleared on wb_en.
  - If set and clear hit the same register in the same cycle, set wins (the newer producer).
  - pending[0] is always 0.
- Hazard, raised when any of the following holds:
  - (rs1!=0 & pending[rs1] & ~(wb_en & wb_addr==rs1))
  - the same condition for rs2
  - (in_rd!=0 & pending[in_rd] & ~(wb_en & wb_addr==in_rd)), i.e. WAW
- Ready and accept: in_ready = ~rst & ~hazard & (~out_valid | out_ready). An accept requires in_valid&in_ready.
- Output register:
  - On accept: out_* are loaded with the bypassed operands, in_op and in_rd; out_valid=1 the next cycle. Latency is exactly 1 cycle from accept to out_valid.
  - If out_valid&out_ready and no accept: out_valid->0 and data is held.
  - If out_valid&~out_ready: all out_* held stable (no change while stalled).
  - Accept with out_valid&out_ready in the same cycle gives back-to-back, full throughput.
- Reset mid-operation: pending ops are discarded. A later wb_en still writes the array but does not corrupt the scoreboard (bit already 0).
- in_op is not interpreted. The encoding is shared with the ALU: 000 ADD, 001 SUB, 010 NOT, 011 AND, 100 OR, 101 XOR, 110 SLT, 111 SEQ.

Decomposition:
- Shared package/header:
  - XLEN, NREG, AW, OPW
  - ALU op-code constants (ALU_ADD..ALU_SEQ)
  - REG_ZERO=0
- Sub-module alu_issue_regfile: 2 async read ports, 1 sync write port, x0 hardwired, bypass inside.
- Scoreboard, hazard logic and output register stay in alu_issue.

Test Plan:
- Reset then read: rst for 2 cycles, issue rs1=3, rs2=0, rd=0 → in_ready=0 during rst; afterwards out_valid=1 next cycle, out_r1=0, out_r2=0.
- Write-then-read bypass: wb_en=1, wb_addr=5, wb_data=0x12345678 in the same cycle as issue rs1=5 → out_r1=0x12345678 one cycle later; x0 write of 0xFFFFFFFF reads back 0.
- RAW stall: issue rd=7; next op rs2=7 → in_ready=0 until wb_en, wb_addr=7, wb_data=0xA5 arrives; accepted that same cycle with out_r2=0xA5.
- Backpressure: out_ready=0 for 3 cycles with out_valid=1 → out_r1/out_r2/out_op/out_rd stable, in_ready=0; out_ready=1 with a new valid op → back-to-back transfer, no bubble.
- WAW / set-wins: pending[4] set, then wb_addr=4 in the same cycle as a new issue with rd=4 → pending[4] remains 1; a subsequent rs1=4 op stalls until the second wb.
- Reset mid-flight: issue rd=9, assert rst before wb → pending cleared, out_valid=0; an op with rs1=9 issues immediately after reset.

Source files
------------

// File: rtl/alu_issue_pkg.sv
// Shared sizes, ALU op-code encoding and hazard helper for the ALU issue stage.
package alu_issue_pkg;

   localparam int XLEN = 32;
   localparam int NREG = 32;
   localparam int AW   = 5;
   localparam int OPW  = 3;

   localparam logic [AW-1:0] REG_ZERO = '0;

   // Op encoding shared with the ALU; the issue stage only passes it through.
   typedef enum logic [OPW-1:0] {
      ALU_ADD = 3'b000,
      ALU_SUB = 3'b001,
      ALU_NOT = 3'b010,
      ALU_AND = 3'b011,
      ALU_OR  = 3'b100,
      ALU_XOR = 3'b101,
      ALU_SLT = 3'b110,
      ALU_SEQ = 3'b111
   } alu_op_e;

   // A register blocks issue while its producer is outstanding, unless that
   // producer is writing back this very cycle (the value is bypassed).
   function automatic logic reg_busy(input logic [NREG-1:0] pend,
                                     input logic [AW-1:0]   r,
                                     input logic            wen,
                                     input logic [AW-1:0]   waddr);
      return (r != REG_ZERO) && pend[r] && !(wen && (waddr == r));
   endfunction

endpackage

// File: rtl/alu_issue_regfile.sv
// Architectural register file: two async read ports with writeback bypass,
// one synchronous write port, register 0 reads as zero.
module alu_issue_regfile
   import alu_issue_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic [AW-1:0]   rs1,
   input  logic [AW-1:0]   rs2,
   output logic [XLEN-1:0] r1,
   output logic [XLEN-1:0] r2,
   input  logic            wb_en,
   input  logic [AW-1:0]   wb_addr,
   input  logic [XLEN-1:0] wb_data
);

   logic [XLEN-1:0] regs [NREG];

   // Write port; reset clears every register so all reads start at zero.
   always_ff @(posedge clk) begin
      if (rst) begin
         // NOTE: this array is deliberately reset (architectural state must read 0 after reset), so it cannot map to a RAM macro.
         for (int i = 0; i < NREG; i++) begin
            regs[i] <= '0;
         end
      end else if (wb_en && (wb_addr != REG_ZERO)) begin
         regs[wb_addr] <= wb_data;
      end
   end

   // Read ports: x0 is constant zero, a same-cycle writeback wins over the array.
   assign r1 = (rs1 == REG_ZERO)                 ? '0      :
               (wb_en && (wb_addr == rs1))       ? wb_data : regs[rs1];
   assign r2 = (rs2 == REG_ZERO)                 ? '0      :
               (wb_en && (wb_addr == rs2))       ? wb_data : regs[rs2];

endmodule

// File: rtl/alu_issue.sv
// Issue stage ahead of the ALU: register read with bypass, pending-write
// scoreboard with RAW/WAW stall, and a one-entry registered output.
module alu_issue
   import alu_issue_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [AW-1:0]   in_rs1,
   input  logic [AW-1:0]   in_rs2,
   input  logic [AW-1:0]   in_rd,
   input  logic [OPW-1:0]  in_op,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_r1,
   output logic [XLEN-1:0] out_r2,
   output logic [OPW-1:0]  out_op,
   output logic [AW-1:0]   out_rd,
   input  logic            wb_en,
   input  logic [AW-1:0]   wb_addr,
   input  logic [XLEN-1:0] wb_data
);

   logic [NREG-1:0] pending;
   logic [NREG-1:0] pending_next;
   logic [XLEN-1:0] rd_val1;
   logic [XLEN-1:0] rd_val2;
   logic            hazard;
   logic            accept;

   alu_issue_regfile u_regfile (
      .clk     (clk),
      .rst     (rst),
      .rs1     (in_rs1),
      .rs2     (in_rs2),
      .r1      (rd_val1),
      .r2      (rd_val2),
      .wb_en   (wb_en),
      .wb_addr (wb_addr),
      .wb_data (wb_data)
   );

   assign hazard   = reg_busy(pending, in_rs1, wb_en, wb_addr) |
                     reg_busy(pending, in_rs2, wb_en, wb_addr) |
                     reg_busy(pending, in_rd,  wb_en, wb_addr);
   assign in_ready = ~rst & ~hazard & (~out_valid | out_ready);
   assign accept   = in_valid & in_ready;

   // Scoreboard next state: writeback clears, a new producer sets (set wins).
   always_comb begin
      // NOTE: default first so every path assigns pending_next (no latch); later statements override earlier ones, which is what lets set beat clear.
      pending_next = pending;
      if (wb_en) begin
         pending_next[wb_addr] = 1'b0;
      end
      if (accept && (in_rd != REG_ZERO)) begin
         pending_next[in_rd] = 1'b1;
      end
      pending_next[0] = 1'b0;
   end

   // Scoreboard register; reset discards all outstanding producers.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignment for all clocked state so every flop samples pre-edge values.
      if (rst) begin
         pending <= '0;
      end else begin
         pending <= pending_next;
      end
   end

   // Output register: load on accept, drop valid when consumed, hold while stalled.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_r1    <= '0;
         out_r2    <= '0;
         out_op    <= '0;
         out_rd    <= '0;
      end else if (accept) begin
         out_valid <= 1'b1;
         out_r1    <= rd_val1;
         out_r2    <= rd_val2;
         out_op    <= in_op;
         out_rd    <= in_rd;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_alu_issue.sv
// Self-checking bench for alu_issue: directed scenarios then random traffic,
// expected outputs queued at accept time and compared by a separate monitor.
module tb_alu_issue;
   import alu_issue_pkg::*;

   logic            clk;
   logic            rst;
   logic            in_valid;
   logic            in_ready;
   logic [AW-1:0]   in_rs1;
   logic [AW-1:0]   in_rs2;
   logic [AW-1:0]   in_rd;
   logic [OPW-1:0]  in_op;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] out_r1;
   logic [XLEN-1:0] out_r2;
   logic [OPW-1:0]  out_op;
   logic [AW-1:0]   out_rd;
   logic            wb_en;
   logic [AW-1:0]   wb_addr;
   logic [XLEN-1:0] wb_data;

   alu_issue dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_rs1    (in_rs1),
      .in_rs2    (in_rs2),
      .in_rd     (in_rd),
      .in_op     (in_op),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_r1    (out_r1),
      .out_r2    (out_r2),
      .out_op    (out_op),
      .out_rd    (out_rd),
      .wb_en     (wb_en),
      .wb_addr   (wb_addr),
      .wb_data   (wb_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [XLEN-1:0] r1;
      logic [XLEN-1:0] r2;
      logic [OPW-1:0]  op;
      logic [AW-1:0]   rd;
   } exp_t;

   // Reference model: architectural values, set of registers with an
   // outstanding producer, and whether an op is sitting at the output.
   logic [XLEN-1:0] m_rf [NREG] = '{default: '0};
   logic [AW-1:0]   inflight [$];
   logic            m_out_valid = 1'b0;
   exp_t            sb [$];

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
      end
   endtask

   function automatic logic is_inflight(input logic [AW-1:0] r);
      foreach (inflight[i]) begin
         if (inflight[i] == r) return 1'b1;
      end
      return 1'b0;
   endfunction

   function automatic logic waits_on(input logic [AW-1:0] r, input logic wen, input logic [AW-1:0] wa);
      return (r != 0) && is_inflight(r) && !(wen && (wa == r));
   endfunction

   function automatic logic [XLEN-1:0] operand(input logic [AW-1:0] r, input logic wen,
                                               input logic [AW-1:0] wa, input logic [XLEN-1:0] wd);
      if (r == 0) return '0;
      if (wen && (wa == r)) return wd;
      return m_rf[r];
   endfunction

   // One clock cycle: drive inputs, check handshake signals against the model,
   // queue the expected output on accept, then advance the model at the edge.
   task automatic cycle(input logic v, input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                        input logic [AW-1:0] rd, input logic [OPW-1:0] op, input logic ordy,
                        input logic wen, input logic [AW-1:0] wa, input logic [XLEN-1:0] wd,
                        input logic r);
      logic exp_ready;
      logic acc;
      in_valid  = v;
      in_rs1    = rs1;
      in_rs2    = rs2;
      in_rd     = rd;
      in_op     = op;
      out_ready = ordy;
      wb_en     = wen;
      wb_addr   = wa;
      wb_data   = wd;
      rst       = r;
      #1;
      exp_ready = !r && !waits_on(rs1, wen, wa) && !waits_on(rs2, wen, wa) &&
                  !waits_on(rd, wen, wa) && (!m_out_valid || ordy);
      check("in_ready", 32'(in_ready), 32'(exp_ready));
      check("out_valid", 32'(out_valid), 32'(m_out_valid));
      acc = v && exp_ready;
      if (acc) begin
         sb.push_back('{operand(rs1, wen, wa, wd), operand(rs2, wen, wa, wd), op, rd});
      end
      @(posedge clk);
      if (r) begin
         foreach (m_rf[i]) m_rf[i] = '0;
         inflight.delete();
         sb.delete();
         m_out_valid = 1'b0;
      end else begin
         if (wen && (wa != 0)) m_rf[wa] = wd;
         if (wen) begin
            for (int i = inflight.size() - 1; i >= 0; i--) begin
               if (inflight[i] == wa) inflight.delete(i);
            end
         end
         if (acc && (rd != 0)) inflight.push_back(rd);
         if (acc) m_out_valid = 1'b1;
         else if (ordy) m_out_valid = 1'b0;
      end
      #1;
   endtask

   // Monitor: whatever the DUT presents must match the oldest queued entry,
   // every cycle it is presented (so stalled outputs must stay stable).
   initial begin
      forever begin
         @(negedge clk);
         if (out_valid === 1'b1) begin
            if (sb.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL sb_underflow at %0t: out_valid=1 with nothing expected", $time);
            end else begin
               check("out_r1", out_r1, sb[0].r1);
               check("out_r2", out_r2, sb[0].r2);
               check("out_op", 32'(out_op), 32'(sb[0].op));
               check("out_rd", 32'(out_rd), 32'(sb[0].rd));
               if (out_ready === 1'b1) void'(sb.pop_front());
            end
         end
      end
   end

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_rs1 = '0; in_rs2 = '0; in_rd = '0; in_op = '0;
      out_ready = 1'b0; wb_en = 1'b0; wb_addr = '0; wb_data = '0;
      @(posedge clk);
      #1;

      // Reset for two cycles with an op offered, then read x3 and x0.
      cycle(1, 3, 0, 0, ALU_ADD, 1, 0, 0, 0, 1);
      cycle(1, 3, 0, 0, ALU_ADD, 1, 0, 0, 0, 1);
      cycle(1, 3, 0, 0, ALU_ADD, 1, 0, 0, 0, 0);

      // Writeback bypass into x5, then x0 write is ignored.
      cycle(1, 5, 0, 0, ALU_SUB, 1, 1, 5, 32'h1234_5678, 0);
      cycle(1, 0, 5, 0, ALU_NOT, 1, 1, 0, 32'hFFFF_FFFF, 0);
      cycle(1, 0, 0, 0, ALU_AND, 1, 0, 0, 0, 0);

      // RAW: producer of x7, consumer stalls until writeback, accepted with bypass.
      cycle(1, 0, 0, 7, ALU_OR, 1, 0, 0, 0, 0);
      repeat (3) cycle(1, 0, 7, 0, ALU_XOR, 1, 0, 0, 0, 0);
      cycle(1, 0, 7, 0, ALU_XOR, 1, 1, 7, 32'h0000_00A5, 0);

      // Backpressure: output held for 3 cycles, then back-to-back transfer.
      cycle(1, 5, 7, 0, ALU_SLT, 1, 0, 0, 0, 0);
      repeat (3) cycle(1, 7, 5, 0, ALU_SEQ, 0, 0, 0, 0, 0);
      cycle(1, 7, 5, 0, ALU_SEQ, 1, 0, 0, 0, 0);
      cycle(1, 5, 5, 0, ALU_ADD, 1, 0, 0, 0, 0);

      // WAW / set-wins on x4; reader of x4 waits for the second writeback.
      cycle(1, 0, 0, 4, ALU_ADD, 1, 0, 0, 0, 0);
      cycle(1, 0, 0, 4, ALU_SUB, 1, 1, 4, 32'h0000_1111, 0);
      repeat (2) cycle(1, 4, 0, 0, ALU_AND, 1, 0, 0, 0, 0);
      cycle(1, 4, 0, 0, ALU_AND, 1, 1, 4, 32'h0000_2222, 0);

      // Reset mid-flight with x9 outstanding; later stale writeback still lands.
      cycle(1, 0, 0, 9, ALU_OR, 1, 0, 0, 0, 0);
      cycle(0, 0, 0, 0, ALU_ADD, 1, 0, 0, 0, 1);
      cycle(1, 9, 0, 0, ALU_XOR, 1, 0, 0, 0, 0);
      cycle(0, 0, 0, 0, ALU_ADD, 1, 1, 9, 32'h0000_0099, 0);
      cycle(1, 9, 9, 0, ALU_SLT, 1, 0, 0, 0, 0);

      // Random traffic over a small register window to provoke hazards.
      for (int n = 0; n < 3000; n++) begin
         logic [AW-1:0] wa;
         logic          wen;
         wen = ($urandom_range(0, 2) == 0);
         if ((inflight.size() > 0) && ($urandom_range(0, 3) != 0))
            wa = inflight[$urandom_range(0, inflight.size() - 1)];
         else
            wa = AW'($urandom_range(0, 7));
         cycle(($urandom_range(0, 3) != 0),
               AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)),
               OPW'($urandom_range(0, 7)), ($urandom_range(0, 3) != 0),
               wen, wa, $urandom, ($urandom_range(0, 299) == 0));
      end

      // Drain: nothing offered, output consumed, every expectation must be seen.
      repeat (4) cycle(0, 0, 0, 0, ALU_ADD, 1, 0, 0, 0, 0);
      check("sb_drain", 32'(sb.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
